// File: rtl/bennett_op_scheduler.sv
// Round-robin arbiter and Bennett-cycle sequencer for one shared adiabatic adder.
// Each grant walks ramp-up, peak hold, ramp-down and release, then returns the peak result.
module bennett_op_scheduler #(
    parameter int unsigned N      = 2,
    parameter int unsigned W      = 8,
    parameter int unsigned STAGES = 11,
    parameter int unsigned HOLD   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    a_in,
    input  logic [N*W-1:0]    b_in,
    input  logic [W:0]        dp_result,
    output logic [N-1:0]      grant,
    output logic              busy,
    output logic [W-1:0]      op_a,
    output logic [W-1:0]      op_b,
    output logic [STAGES-1:0] clkp,
    output logic [STAGES-1:0] clkn,
    output logic [W:0]        result,
    output logic [N-1:0]      done
);

    localparam int unsigned MaxCnt = (STAGES > HOLD) ? STAGES : HOLD;
    localparam int unsigned CW     = $clog2(MaxCnt + 1);
    localparam int unsigned PW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastStage = CW'(STAGES - 1);
    localparam logic [CW-1:0] LastHold  = CW'(HOLD - 1);
    localparam logic [PW-1:0] LastReq   = PW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRampUp,
        StPeak,
        StRampDown,
        StRelease
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     owner_q;
    logic [N-1:0]      grant_q;
    logic [N-1:0]      done_q;
    logic [W-1:0]      op_a_q;
    logic [W-1:0]      op_b_q;
    logic [W:0]        result_q;
    logic [STAGES-1:0] clkp_q;

    logic              found;
    logic [PW-1:0]     sel_idx;
    int unsigned       idx;

    // First asserted request at or after the pointer, wrapping around.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                found   = 1'b1;
                sel_idx = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            clkp_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    clkp_q  <= '0;
                    done_q  <= '0;
                    grant_q <= '0;
                    if (found) begin
                        grant_q <= N'(1) << sel_idx;
                        owner_q <= sel_idx;
                        op_a_q  <= a_in[sel_idx*W +: W];
                        op_b_q  <= b_in[sel_idx*W +: W];
                        cnt_q   <= '0;
                        clkp_q  <= STAGES'(1);
                        state_q <= StRampUp;
                    end
                end
                StRampUp: begin
                    if (cnt_q == LastStage) begin
                        cnt_q   <= '0;
                        state_q <= StPeak;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        clkp_q <= (clkp_q << 1) | STAGES'(1);
                    end
                end
                StPeak: begin
                    if (cnt_q == LastHold) begin
                        result_q <= dp_result;
                        cnt_q    <= '0;
                        clkp_q   <= clkp_q >> 1;
                        state_q  <= StRampDown;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRampDown: begin
                    if (cnt_q == LastStage) begin
                        cnt_q   <= '0;
                        clkp_q  <= '0;
                        done_q  <= grant_q;
                        state_q <= StRelease;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        clkp_q <= clkp_q >> 1;
                    end
                end
                StRelease: begin
                    done_q  <= '0;
                    grant_q <= '0;
                    clkp_q  <= '0;
                    cnt_q   <= '0;
                    ptr_q   <= (owner_q == LastReq) ? '0 : owner_q + 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    clkp_q  <= '0;
                    grant_q <= '0;
                    done_q  <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign grant  = grant_q;
    assign busy   = (state_q != StIdle);
    assign op_a   = op_a_q;
    assign op_b   = op_b_q;
    assign clkp   = clkp_q;
    assign clkn   = ~clkp_q;
    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bennett_op_scheduler.sv
// Scoreboard bench for bennett_op_scheduler: default instance plus a HOLD=3 instance.
module tb_bennett_op_scheduler;

    localparam int N = 2;
    localparam int W = 8;
    localparam int S = 11;

    typedef struct packed {
        logic [N-1:0] who;
        logic [W:0]   sum;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in, b_in;
    logic [W:0]     dp_result;
    logic [N-1:0]   grant, done;
    logic           busy;
    logic [W-1:0]   op_a, op_b;
    logic [S-1:0]   clkp, clkn;
    logic [W:0]     result;

    logic           rst_h;
    logic [N-1:0]   req_h;
    logic [N*W-1:0] a_h, b_h;
    logic [W:0]     dp_h;
    logic [N-1:0]   grant_h, done_h;
    logic           busy_h;
    logic [W-1:0]   op_a_h, op_b_h;
    logic [S-1:0]   clkp_h, clkn_h;
    logic [W:0]     result_h;

    int   vectors = 0;
    int   errors  = 0;
    exp_t sbq[$];
    exp_t e;

    // Datapath model: the adder sums the latched operands.
    assign dp_result = {1'b0, op_a} + {1'b0, op_b};

    bennett_op_scheduler #(.N(N), .W(W), .STAGES(S), .HOLD(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
        .dp_result(dp_result), .grant(grant), .busy(busy), .op_a(op_a), .op_b(op_b),
        .clkp(clkp), .clkn(clkn), .result(result), .done(done)
    );

    bennett_op_scheduler #(.N(N), .W(W), .STAGES(S), .HOLD(3)) u_dut_h3 (
        .clk(clk), .reset_n(rst_h), .req(req_h), .a_in(a_h), .b_in(b_h),
        .dp_result(dp_h), .grant(grant_h), .busy(busy_h), .op_a(op_a_h), .op_b(op_b_h),
        .clkp(clkp_h), .clkn(clkn_h), .result(result_h), .done(done_h)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse pops one expected owner/result.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            vectors++;
            if (clkn !== ~clkp) begin
                errors++;
                $display("FAIL clkn_compl: clkn=%h required %h", clkn, ~clkp);
            end
            if (done !== '0) begin
                vectors++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=%b required 00", done);
                end else begin
                    e = sbq.pop_front();
                    if (done !== e.who || result !== e.sum) begin
                        errors++;
                        $display("FAIL sb_result: done=%b result=%h required done=%b result=%h",
                                 done, result, e.who, e.sum);
                    end
                end
            end
        end
    end

    task automatic apply_reset;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        req     = '0;
        sbq.delete();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        vectors++;
        if (clkp !== '0 || clkn !== '1 || grant !== '0 || busy !== 1'b0 || done !== '0 ||
            op_a !== '0 || op_b !== '0 || result !== '0) begin
            errors++;
            $display("FAIL reset_state: clkp=%h clkn=%h grant=%b busy=%b done=%b op=%h/%h res=%h required 000/7ff/00/0/00/00/00/000",
                     clkp, clkn, grant, busy, done, op_a, op_b, result);
        end
    endtask

    task automatic test_single;
        apply_reset();
        a_in = {8'h00, 8'h5A};
        b_in = {8'h00, 8'h33};
        req  = 2'b01;
        sbq.push_back(exp_t'{who: 2'b01, sum: 9'h08D});
        for (int c = 1; c <= 25; c++) begin
            logic [S-1:0] ec;
            logic [N-1:0] eg, ed;
            tick();
            if (c <= 11)      ec = S'((1 << c) - 1);
            else if (c == 12) ec = '1;
            else if (c <= 23) ec = S'((1 << (23 - c)) - 1);
            else              ec = '0;
            eg = (c <= 24) ? 2'b01 : 2'b00;
            ed = (c == 24) ? 2'b01 : 2'b00;
            vectors++;
            if (clkp !== ec || grant !== eg || busy !== (c <= 24) || done !== ed) begin
                errors++;
                $display("FAIL single_c%0d: clkp=%h grant=%b busy=%b done=%b required %h/%b/%b/%b",
                         c, clkp, grant, busy, done, ec, eg, (c <= 24), ed);
            end
            if (c == 24) req = '0;
        end
        vectors++;
        if (result !== 9'h08D) begin
            errors++;
            $display("FAIL single_result: result=%h required 08d", result);
        end
    endtask

    task automatic test_pair;
        apply_reset();
        a_in = {8'hF0, 8'h10};
        b_in = {8'h31, 8'h20};
        req  = 2'b11;
        sbq.push_back(exp_t'{who: 2'b01, sum: 9'h030});
        sbq.push_back(exp_t'{who: 2'b10, sum: 9'h121});
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL pair_first_grant: grant=%b required 01", grant);
        end
        for (int k = 0; k < 40 && done === '0; k++) tick();
        vectors++;
        if (done !== 2'b01) begin
            errors++;
            $display("FAIL pair_done0: done=%b required 01", done);
        end
        req = 2'b10;
        tick();
        vectors++;
        if (grant !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pair_idle: grant=%b busy=%b required 00/0", grant, busy);
        end
        tick();
        vectors++;
        if (grant !== 2'b10 || op_a !== 8'hF0 || op_b !== 8'h31) begin
            errors++;
            $display("FAIL pair_second_grant: grant=%b op=%h/%h required 10 f0/31",
                     grant, op_a, op_b);
        end
        for (int k = 0; k < 40 && done === '0; k++) tick();
        vectors++;
        if (done !== 2'b10) begin
            errors++;
            $display("FAIL pair_done1: done=%b required 10", done);
        end
        req = '0;
        tick();
        vectors++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL pair_drain: pending=%0d required 0", sbq.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] eg[3] = '{2'b01, 2'b10, 2'b01};
        logic [W-1:0] ea, eb, pa;
        logic [W:0]   es;
        logic         stable;
        apply_reset();
        a_in = {8'hC1, 8'h07};
        b_in = {8'h4F, 8'h19};
        req  = 2'b11;
        pa   = '0;
        for (int op = 0; op < 3; op++) begin
            ea = (eg[op] == 2'b01) ? 8'h07 : 8'hC1;
            eb = (eg[op] == 2'b01) ? 8'h19 : 8'h4F;
            es = {1'b0, ea} + {1'b0, eb};
            sbq.push_back(exp_t'{who: eg[op], sum: es});
            if (op > 0) begin
                tick();
                vectors++;
                if (busy !== 1'b0 || op_a !== pa) begin
                    errors++;
                    $display("FAIL b2b_idle%0d: busy=%b op_a=%h required 0/%h", op, busy, op_a, pa);
                end
            end
            tick();
            vectors++;
            if (grant !== eg[op] || op_a !== ea || op_b !== eb) begin
                errors++;
                $display("FAIL b2b_grant%0d: grant=%b op=%h/%h required %b %h/%h",
                         op, grant, op_a, op_b, eg[op], ea, eb);
            end
            a_in   = ~{8'hC1, 8'h07};
            b_in   = ~{8'h4F, 8'h19};
            stable = 1'b1;
            for (int k = 0; k < 40 && done === '0; k++) begin
                tick();
                if (op_a !== ea || op_b !== eb) stable = 1'b0;
            end
            vectors++;
            if (!stable || done !== eg[op]) begin
                errors++;
                $display("FAIL b2b_hold%0d: stable=%b done=%b required 1/%b", op, stable, done, eg[op]);
            end
            a_in = {8'hC1, 8'h07};
            b_in = {8'h4F, 8'h19};
            pa   = ea;
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid;
        a_in = {8'h22, 8'h11};
        b_in = {8'h44, 8'h33};
        req  = 2'b01;
        sbq.push_back(exp_t'{who: 2'b01, sum: 9'h044});
        for (int c = 1; c <= 6; c++) tick();
        vectors++;
        if (clkp !== 11'h03F) begin
            errors++;
            $display("FAIL mid_k5: clkp=%h required 03f", clkp);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (clkp !== '0 || clkn !== 11'h7FF || grant !== '0 || busy !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL mid_reset: clkp=%h clkn=%h grant=%b busy=%b result=%h required 000/7ff/00/0/000",
                     clkp, clkn, grant, busy, result);
        end
        sbq.delete();
        req = '0;
        tick();
        reset_n = 1'b1;
        req     = 2'b10;
        sbq.push_back(exp_t'{who: 2'b10, sum: 9'h066});
        tick();
        vectors++;
        if (grant !== 2'b10 || clkp !== 11'h001) begin
            errors++;
            $display("FAIL mid_restart: grant=%b clkp=%h required 10/001", grant, clkp);
        end
        for (int k = 0; k < 40 && done === '0; k++) tick();
        vectors++;
        if (done !== 2'b10) begin
            errors++;
            $display("FAIL mid_done: done=%b required 10", done);
        end
        req = '0;
        tick();
    endtask

    task automatic test_hold3;
        int dcycle = 0;
        req_h = 2'b01;
        a_h   = {8'h00, 8'h01};
        b_h   = {8'h00, 8'h02};
        dp_h  = 9'h1FF;
        for (int c = 1; c <= 27; c++) begin
            tick();
            case (c)
                12:      dp_h = 9'h011;
                13:      dp_h = 9'h022;
                14:      dp_h = 9'h033;
                default: dp_h = 9'h1FF;
            endcase
            if (c >= 12 && c <= 14) begin
                vectors++;
                if (clkp_h !== '1 || clkn_h !== '0 || result_h !== '0 || grant_h !== 2'b01) begin
                    errors++;
                    $display("FAIL h3_peak_c%0d: clkp=%h result=%h grant=%b required 7ff/000/01",
                             c, clkp_h, result_h, grant_h);
                end
            end
            if (c == 15) begin
                vectors++;
                if (clkp_h !== 11'h3FF || result_h !== 9'h033) begin
                    errors++;
                    $display("FAIL h3_capture: clkp=%h result=%h required 3ff/033", clkp_h, result_h);
                end
            end
            if (done_h !== '0 && dcycle == 0) dcycle = c;
            if (c == 26) req_h = '0;
        end
        vectors++;
        if (dcycle != 26 || busy_h !== 1'b0 || op_a_h !== 8'h01 || op_b_h !== 8'h02) begin
            errors++;
            $display("FAIL h3_done: done_cycle=%0d busy=%b op=%h/%h required 26/0/01/02",
                     dcycle, busy_h, op_a_h, op_b_h);
        end
    endtask

    task automatic test_pulse;
        int pulses = 0;
        int dcycle = 0;
        int late   = 0;
        apply_reset();
        a_in = {8'h00, 8'hFF};
        b_in = {8'h00, 8'h01};
        req  = 2'b01;
        sbq.push_back(exp_t'{who: 2'b01, sum: 9'h100});
        tick();
        req = '0;
        for (int c = 1; c <= 30; c++) begin
            if (done !== '0) begin
                pulses++;
                dcycle = c;
            end
            if (c > 24 && grant !== '0) late++;
            tick();
        end
        vectors++;
        if (pulses != 1 || dcycle != 24 || late != 0) begin
            errors++;
            $display("FAIL pulse_req: pulses=%0d done_cycle=%0d late_grants=%0d required 1/24/0",
                     pulses, dcycle, late);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        rst_h   = 1'b0;
        req     = '0;
        req_h   = '0;
        a_in    = '0;
        b_in    = '0;
        a_h     = '0;
        b_h     = '0;
        dp_h    = '0;
        #2;
        test_reset();
        tick();
        reset_n = 1'b1;
        rst_h   = 1'b1;
        test_single();
        test_pair();
        test_back_to_back();
        test_reset_mid();
        test_hold3();
        test_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
